// File: rtl/fft_data_arranger_if.sv
// Control/data bundle between FFT controller, PE0 and the data arranger.
// master: controller/PE0 side (drives codes and samples); slave: arranger.
interface fft_data_arranger_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] din_re;
    logic [DATA_WIDTH-1:0] din_im;
    logic [3:0]            wen_ctrl;
    logic [3:0]            waddr_ctrl;
    logic [3:0]            ren_ctrl;
    logic [3:0]            raddr_ctrl;
    logic [DATA_WIDTH-1:0] dout_re;
    logic [DATA_WIDTH-1:0] dout_im;
    logic                  dout_vld;
    logic                  cfg_err;

    modport master (
        output din_re, din_im,
        output wen_ctrl, waddr_ctrl,
        output ren_ctrl, raddr_ctrl,
        input  dout_re, dout_im,
        input  dout_vld, cfg_err
    );

    modport slave (
        input  din_re, din_im,
        input  wen_ctrl, waddr_ctrl,
        input  ren_ctrl, raddr_ctrl,
        output dout_re, dout_im,
        output dout_vld, cfg_err
    );
endinterface

// File: rtl/fft_data_arranger.sv
// In-place 8x8 bank reorder buffer for the 64-point DIF FFT (read-before-write).
// Ports: clk, rst_n (sync, active-low), da (slave: codes, samples, dout, cfg_err).
module fft_data_arranger #(
    parameter int DATA_WIDTH = 16,
    parameter int BANKS      = 8,
    parameter int DEPTH      = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    fft_data_arranger_if.slave da
);
    localparam int SW = 2 * DATA_WIDTH;

    logic [SW-1:0] mem [BANKS][DEPTH];

    logic wr_ok;
    logic rd_ok;
    logic wr_bad;
    logic rd_bad;

    logic [DATA_WIDTH-1:0] dout_re_q;
    logic [DATA_WIDTH-1:0] dout_im_q;
    logic                  dout_vld_q;
    logic                  cfg_err_q;

    // Bit 3 of each code is the idle/disable flag; both halves of a pair
    // must agree, otherwise the pair is inconsistent and the op is dropped.
    assign wr_ok  = ~da.wen_ctrl[3] & ~da.waddr_ctrl[3];
    assign rd_ok  = ~da.ren_ctrl[3] & ~da.raddr_ctrl[3];
    assign wr_bad = da.wen_ctrl[3] ^ da.waddr_ctrl[3];
    assign rd_bad = da.ren_ctrl[3] ^ da.raddr_ctrl[3];

    // Storage is never cleared; a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (rst_n && wr_ok) begin
            mem[da.wen_ctrl[2:0]][da.waddr_ctrl[2:0]] <= {da.din_re, da.din_im};
        end
    end

    // The read samples mem before this edge's write lands, which gives
    // read-before-write on a same-location collision.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_re_q  <= '0;
            dout_im_q  <= '0;
            dout_vld_q <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            if (rd_ok) begin
                {dout_re_q, dout_im_q} <= mem[da.ren_ctrl[2:0]][da.raddr_ctrl[2:0]];
                dout_vld_q <= 1'b1;
            end else begin
                dout_vld_q <= 1'b0;
            end
            if (wr_bad || rd_bad) begin
                cfg_err_q <= 1'b1;
            end
        end
    end

    assign da.dout_re  = dout_re_q;
    assign da.dout_im  = dout_im_q;
    assign da.dout_vld = dout_vld_q;
    assign da.cfg_err  = cfg_err_q;
endmodule

// File: tb/tb_fft_data_arranger.sv
// Randomized + directed bench for fft_data_arranger against a flat-array model.
// Model: 64-entry sample store indexed bank*8+entry, sticky error flag.
module tb_fft_data_arranger;
    logic clk = 1'b0;
    logic rst_n;

    fft_data_arranger_if #(.DATA_WIDTH(16)) da ();

    fft_data_arranger #(
        .DATA_WIDTH(16),
        .BANKS(8),
        .DEPTH(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .da(da.slave)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    logic [31:0] m_mem [64];
    bit          m_wr  [64];
    logic [31:0] m_dout;
    bit          m_dknown;
    bit          m_vld;
    bit          m_err;

    logic [31:0] frame_a [64];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One clock: drive codes, advance the model across the edge, then check.
    task automatic cyc(input logic [3:0] we, input logic [3:0] wa,
                       input logic [3:0] re, input logic [3:0] ra,
                       input logic [15:0] dr, input logic [15:0] di,
                       input logic rs);
        int ridx;
        int widx;
        da.wen_ctrl   = we;
        da.waddr_ctrl = wa;
        da.ren_ctrl   = re;
        da.raddr_ctrl = ra;
        da.din_re     = dr;
        da.din_im     = di;
        rst_n         = rs;
        @(posedge clk);
        if (!rs) begin
            m_dout   = '0;
            m_dknown = 1'b1;
            m_vld    = 1'b0;
            m_err    = 1'b0;
        end else begin
            if ((we[3] != wa[3]) || (re[3] != ra[3])) m_err = 1'b1;
            if (!re[3] && !ra[3]) begin
                ridx     = int'(re[2:0]) * 8 + int'(ra[2:0]);
                m_vld    = 1'b1;
                m_dknown = m_wr[ridx];
                m_dout   = m_mem[ridx];
            end else begin
                m_vld = 1'b0;
            end
            if (!we[3] && !wa[3]) begin
                widx        = int'(we[2:0]) * 8 + int'(wa[2:0]);
                m_mem[widx] = {dr, di};
                m_wr[widx]  = 1'b1;
            end
        end
        #1;
        check("dout_vld", 32'(da.dout_vld), 32'(m_vld));
        check("cfg_err", 32'(da.cfg_err), 32'(m_err));
        if (m_dknown) check("dout", {da.dout_re, da.dout_im}, m_dout);
    endtask

    task automatic wr(input int idx, input logic [15:0] dr, input logic [15:0] di);
        cyc({1'b0, 3'(idx / 8)}, {1'b0, 3'(idx % 8)}, 4'h8, 4'h8, dr, di, 1'b1);
    endtask

    task automatic rd(input int idx);
        cyc(4'h8, 4'h8, {1'b0, 3'(idx / 8)}, {1'b0, 3'(idx % 8)}, 16'h0, 16'h0, 1'b1);
    endtask

    task automatic rdwr(input int idx, input logic [15:0] dr, input logic [15:0] di);
        cyc({1'b0, 3'(idx / 8)}, {1'b0, 3'(idx % 8)},
            {1'b0, 3'(idx / 8)}, {1'b0, 3'(idx % 8)}, dr, di, 1'b1);
    endtask

    task automatic idle();
        cyc(4'h8, 4'h8, 4'h8, 4'h8, 16'h0, 16'h0, 1'b1);
    endtask

    function automatic int tr(input int n);
        return (n % 8) * 8 + (n / 8);
    endfunction

    initial begin
        logic [15:0] r;
        logic [15:0] i;
        for (int k = 0; k < 64; k++) begin
            m_wr[k]  = 1'b0;
            m_mem[k] = '0;
        end
        m_dknown = 1'b0;
        m_vld    = 1'b0;
        m_err    = 1'b0;

        // reset held 3 cycles with valid-looking codes: nothing written
        for (int k = 0; k < 3; k++) cyc(4'h0, 4'h0, 4'h0, 4'h0, 16'h7777, 16'h7777, 1'b0);
        check("rst_dout", {da.dout_re, da.dout_im}, 32'h0);

        // full fill then readback in natural order
        for (int n = 0; n < 64; n++) wr(n, 16'(n), 16'(-n));
        for (int n = 0; n < 64; n++) begin
            rd(n);
            check("fill_re", 32'(da.dout_re), 32'(16'(n)));
        end

        // read-before-write collision at [3][5]
        wr(29, 16'h1111, 16'h1111);
        rdwr(29, 16'h2222, 16'h2222);
        check("coll_old", 32'(da.dout_re), 32'h1111);
        rd(29);
        check("coll_new", 32'(da.dout_re), 32'h2222);

        // idle code holds dout and writes nothing
        wr(12, 16'h00AB, 16'h00AB);
        rd(12);
        idle();
        idle();
        check("hold", 32'(da.dout_re), 32'h00AB);
        rd(12);

        // reset mid-stream drops the in-flight write
        wr(0, 16'h5555, 16'h5555);
        cyc(4'h0, 4'h0, 4'h8, 4'h8, 16'h7777, 16'h7777, 1'b0);
        rd(0);
        check("rst_nowr", 32'(da.dout_re), 32'h5555);

        // two-frame transpose: A bank-major, B entry-major over A, then read B
        for (int n = 0; n < 64; n++) begin
            frame_a[n] = {16'($urandom), 16'($urandom)};
            wr(n, frame_a[n][31:16], frame_a[n][15:0]);
        end
        for (int n = 0; n < 64; n++) begin
            rdwr(tr(n), 16'($urandom), 16'($urandom));
            check("xpose", {da.dout_re, da.dout_im}, frame_a[tr(n)]);
        end
        for (int n = 0; n < 64; n++) rd(tr(n));

        // random consistent traffic: valid or idle codes, independent R/W
        for (int k = 0; k < 600; k++) begin
            logic [3:0] we;
            logic [3:0] wa;
            logic [3:0] re;
            logic [3:0] ra;
            r = 16'($urandom);
            i = 16'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                we = 4'h8;
                wa = 4'h8;
            end else begin
                we = {1'b0, 3'($urandom)};
                wa = {1'b0, 3'($urandom)};
            end
            if ($urandom_range(0, 4) == 0) begin
                re = 4'h8;
                ra = 4'h8;
            end else begin
                re = {1'b0, 3'($urandom)};
                ra = {1'b0, 3'($urandom)};
            end
            cyc(we, wa, re, ra, r, i, 1'b1);
        end

        // inconsistent write code: error sets, bank 2 untouched, sticky
        cyc(4'h2, 4'h8, 4'h8, 4'h8, 16'hDEAD, 16'hBEEF, 1'b1);
        check("err_set", 32'(da.cfg_err), 32'h1);
        for (int e = 0; e < 8; e++) rd(16 + e);
        // inconsistent read code: no valid read, dout holds
        cyc(4'h8, 4'h8, 4'h8, 4'h3, 16'h0, 16'h0, 1'b1);
        // random inconsistent codes after the error is already set
        for (int k = 0; k < 50; k++) begin
            cyc(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                16'($urandom), 16'($urandom), 1'b1);
        end
        check("err_sticky", 32'(da.cfg_err), 32'h1);
        cyc(4'h8, 4'h8, 4'h8, 4'h8, 16'h0, 16'h0, 1'b0);
        check("err_clr", 32'(da.cfg_err), 32'h0);
        for (int n = 0; n < 64; n++) rd(n);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/fft_data_arranger.md
# fft_data_arranger

Ping-pong-free, in-place reorder buffer for the 64-point radix-2 DIF pipeline. It sits directly downstream of the PE0 butterfly and is driven by the `da_*_ctrl` outputs of the FFT controller. It stores one 64-sample complex frame across 8 banks of 8 entries. It returns the samples in natural order, using read-before-write on the same location so that consecutive frames share storage.

## Interface
- DATA_WIDTH, 16, width of each real/imag component (two's complement, passed through unmodified)
- BANKS, 8, number of banks; fixed at 8 for the 64-point build
- DEPTH, 8, entries per bank; fixed at 8

- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- din_re  in  DATA_WIDTH  real part of the PE0 output sample
- din_im  in  DATA_WIDTH  imaginary part of the PE0 output sample
- wen_ctrl  in  4  write bank select; bit3=1 means no write, bits[2:0] give the bank
- waddr_ctrl  in  4  write entry; bit3=1 means idle, bits[2:0] give the entry
- ren_ctrl  in  4  read bank select; bit3=1 means no read, bits[2:0] give the bank
- raddr_ctrl  in  4  read entry; bit3=1 means idle, bits[2:0] give the entry
- dout_re  out  DATA_WIDTH  registered real read data
- dout_im  out  DATA_WIDTH  registered imaginary read data
- dout_vld  out  1  registered; high in the cycle dout carries a fresh read
- cfg_err  out  1  sticky flag; set on an inconsistent control code

## Operation
- Storage: mem[bank][entry], 64 × 2×DATA_WIDTH flops or LUTRAM. Reset does **not** clear storage contents.
- Write: when wen_ctrl[3]==0 and waddr_ctrl[3]==0, {din_re,din_im} is written to mem[wen_ctrl[2:0]][waddr_ctrl[2:0]] at the clk edge.
- Read: when ren_ctrl[3]==0 and raddr_ctrl[3]==0, mem[ren_ctrl[2:0]][raddr_ctrl[2:0]] is captured into dout_re/dout_im at the clk edge, and dout_vld is set to 1.
- Read with no valid code:
  - dout_vld is set to 0.
  - dout_re/dout_im hold their previous value.
- Same-location collision (same bank and same entry, read and write in one cycle): read-before-write. dout receives the OLD content, and the new sample is stored.
- A read and a write to different locations in the same cycle are independent.
- cfg_err is set on either mismatch:
  - exactly one of wen_ctrl[3] and waddr_ctrl[3] is 1;
  - exactly one of ren_ctrl[3] and raddr_ctrl[3] is 1.
- When cfg_err sets, the offending write and/or read is suppressed. cfg_err clears only on reset.
- Frame use by the controller: the first frame is written without reads. Every later frame reads the previous frame from each location before overwriting it. Bank/entry roles swap every frame (bank-major vs entry-major), which yields the transpose/bit-reversal. This block is agnostic to the addressing pattern.

## Timing
- Reset (rst_n==0 at a clk edge) forces:
  - dout_re=0, dout_im=0;
  - dout_vld=0;
  - cfg_err=0;
  - no write in that cycle.
- Reset mid-frame: in-flight writes in the reset cycle are dropped, and stored contents are left unchanged.
- Write latency: data written at edge k is readable by a read issued in cycle k+1. A read in the same cycle k returns the old value.
- Read latency: 1 cycle. Control presented in cycle k gives dout and dout_vld valid after edge k, which aligns with the controller's registered valid output.
- Sample latency: an input sample reappears 64 valid cycles later (one frame).
- No stalls. The controller gates all codes, and an idle code (4'b1000) on every control input is a no-op.
- Throughput: one write and one read per cycle, sustained.

## Test plan
- Reset behaviour: hold rst_n=0 for 3 cycles with wen=ren=0, addr=0 -> dout_re=dout_im=0, dout_vld=0, cfg_err=0, and no write occurs.
- Full fill and readback: write din_re=n, din_im=-n to bank n[5:3], entry n[2:0] for n=0..63, then read in the same order -> dout_re=n, dout_im=-n one cycle after each read, with dout_vld=1 for 64 cycles.
- Read-before-write collision: mem[3][5]=0x1111, then in one cycle write 0x2222 and read [3][5] -> dout=0x1111. The next read of [3][5] returns 0x2222.
- Idle code and hold: drive ren=raddr=8 after a read returning 0x00AB -> dout_vld=0 and dout stays 0x00AB. wen=waddr=8 writes nothing.
- cfg_err: drive wen=2 with waddr=8 -> cfg_err=1 on the next cycle, mem[2][*] unchanged, and cfg_err stays 1 until rst_n=0.
- Two-frame transpose: frame A written bank-major, then frame B written entry-major while reading the same locations -> the output sequence equals frame A transposed, and a third pass returns frame B.
